slurm16_memory_arbiter: RTL and testbench

//  Shares one single-ported SRAM between N_MASTERS bus masters. Master 0 is the CPU memory interface
//  (memory_valid/memory_wr/memory_ready); masters 1..N-1 are DMA engines (audio, GFX, flash).

---
 rtl/slurm16_memory_arbiter_if.sv | 24 ++
 rtl/slurm16_memory_arbiter.sv | 139 +++++++++++++
 tb/tb_slurm16_memory_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/slurm16_memory_arbiter_if.sv
// slurm16 memory arbiter master-side bus.
// Packed per-master request fields plus the shared read data.
interface slurm16_memory_arbiter_if #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 16,
    parameter int N_MASTERS    = 4
);
    logic [N_MASTERS-1:0]              m_valid;
    logic [N_MASTERS-1:0]              m_wr;
    logic [N_MASTERS*ADDRESS_BITS-1:0] m_addr;
    logic [N_MASTERS*BITS-1:0]         m_wdata;
    logic [N_MASTERS-1:0]              m_ready;
    logic [BITS-1:0]                   m_rdata;

    modport master (
        output m_valid, m_wr, m_addr, m_wdata,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_valid, m_wr, m_addr, m_wdata,
        output m_ready, m_rdata
    );
endinterface

// File: rtl/slurm16_memory_arbiter.sv
// slurm16 single-port SRAM arbiter: round-robin, bounded bursts.
// Optional CPU pre-emption: SLURM16_ARB_CPU_PRIORITY_EN.
module slurm16_memory_arbiter #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 16,
    parameter int N_MASTERS    = 4,
    parameter int MAX_BURST    = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    slurm16_memory_arbiter_if.slave bus,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [BITS-1:0]         mem_wdata,
    output logic                    mem_wr,
    input  logic [BITS-1:0]         mem_rdata,
    output logic [2:0]              grant_id,
    output logic                    busy
);
    typedef enum logic {IDLE, OWNED} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);
    localparam logic [2:0] LAST_IDX  = 3'(N_MASTERS - 1);

    state_t                  state, state_n;
    logic [2:0]              owner, owner_n;
    logic [2:0]              rr_ptr, rr_ptr_n;
    logic [7:0]              burst_cnt, burst_cnt_n;
    logic [ADDRESS_BITS-1:0] hold_addr, own_addr;
    logic [BITS-1:0]         hold_wdata, own_wdata;
    logic [N_MASTERS-1:0]    own_valid_vec, own_wr_vec;
    logic                    own_valid, own_wr;
    logic                    access, release_now, cpu_preempt;
    logic [2:0]              after_owner;

    // First requester at or after 'from', wrapping modulo N_MASTERS.
    function automatic logic [2:0] pick(
        input logic [N_MASTERS-1:0] req,
        input logic [2:0]           from
    );
        logic [2:0]           sel;
        logic                 hit;
        logic [N_MASTERS-1:0] sh;
        int                   idx;
        sel = from;
        hit = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx = (int'(from) + i) % N_MASTERS;
            sh  = req >> idx;
            if (!hit && sh[0]) begin
                sel = 3'(idx);
                hit = 1'b1;
            end
        end
        return sel;
    endfunction

    // Owner's request fields muxed out of the packed buses.
    always_comb begin
        own_valid_vec = bus.m_valid >> owner;
        own_wr_vec    = bus.m_wr >> owner;
        own_valid     = own_valid_vec[0];
        own_wr        = own_wr_vec[0];
        own_addr      = ADDRESS_BITS'(bus.m_addr >> (int'(owner) * ADDRESS_BITS));
        own_wdata     = BITS'(bus.m_wdata >> (int'(owner) * BITS));
        after_owner   = (owner == LAST_IDX) ? 3'd0 : owner + 3'd1;
    end

    // Next-state: grant from IDLE, burst counting and release/hand-over.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_ptr_n    = rr_ptr;
        burst_cnt_n = burst_cnt;
        access      = 1'b0;
        release_now = 1'b0;
        cpu_preempt = 1'b0;
        unique case (state)
            IDLE: begin
                if (|bus.m_valid) begin
                    state_n     = OWNED;
                    owner_n     = pick(bus.m_valid, rr_ptr);
                    burst_cnt_n = '0;
                end
            end
            OWNED: begin
                access = own_valid;
`ifdef SLURM16_ARB_CPU_PRIORITY_EN
                cpu_preempt = bus.m_valid[0] && (owner != 3'd0);
`endif
                if (access) burst_cnt_n = burst_cnt + 8'd1;
                release_now = !own_valid || (burst_cnt == LAST_BEAT)
                            || cpu_preempt;
                if (release_now) begin
                    rr_ptr_n    = after_owner;
                    burst_cnt_n = '0;
                    if (cpu_preempt) owner_n = 3'd0;
                    else if (|bus.m_valid)
                        owner_n = pick(bus.m_valid, after_owner);
                    else state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs: reset suppresses any access or write in the same cycle.
    always_comb begin
        busy        = (state == OWNED);
        grant_id    = owner;
        mem_addr    = busy ? own_addr : hold_addr;
        mem_wdata   = busy ? own_wdata : hold_wdata;
        mem_wr      = access & own_wr & ~RST;
        bus.m_ready = RST ? '0 : (N_MASTERS'(access) << owner);
        bus.m_rdata = mem_rdata;
    end

    // Arbitration state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            burst_cnt <= burst_cnt_n;
        end
    end

    // Keep the last driven SRAM address/data stable while idle.
    always_ff @(posedge CLK) begin
        if (busy) begin
            hold_addr  <= own_addr;
            hold_wdata <= own_wdata;
        end
    end
endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
// Bench for slurm16_memory_arbiter: rule-level model plus directed
// vectors with hand-computed expectations.
module tb_slurm16_memory_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MB = 4;
`ifdef SLURM16_ARB_CPU_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    slurm16_memory_arbiter_if #(.BITS(DW), .ADDRESS_BITS(AW), .N_MASTERS(N)) bus ();
    slurm16_memory_arbiter_if #(.BITS(DW), .ADDRESS_BITS(AW), .N_MASTERS(N)) bus2 ();

    logic [AW-1:0] mem_addr, mem_addr2;
    logic [DW-1:0] mem_wdata, mem_wdata2, mem_rdata;
    logic [DW-1:0] mem_rdata2 = '0;
    logic          mem_wr, mem_wr2, busy, busy2;
    logic [2:0]    grant_id, grant_id2;

    slurm16_memory_arbiter #(
        .BITS(DW), .ADDRESS_BITS(AW), .N_MASTERS(N), .MAX_BURST(MB)
    ) dut (
        .CLK(clk), .RST(rst), .bus(bus.slave),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .grant_id(grant_id), .busy(busy)
    );

    slurm16_memory_arbiter #(
        .BITS(DW), .ADDRESS_BITS(AW), .N_MASTERS(N), .MAX_BURST(2)
    ) dut2 (
        .CLK(clk), .RST(rst), .bus(bus2.slave),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_wr(mem_wr2),
        .mem_rdata(mem_rdata2), .grant_id(grant_id2), .busy(busy2)
    );

    // SRAM: synchronous write, read data one cycle after address.
    logic [DW-1:0] sram [0:65535];
    always @(posedge clk) begin
        if (mem_wr) sram[mem_addr] <= mem_wdata;
        mem_rdata <= sram[mem_addr];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++)
            if (((v >> ((p + i) % N)) & 1) != 0) return (p + i) % N;
        return -1;
    endfunction

    // Model: owner (-1 when idle), pointer, accesses in current grant.
    int        mo = -1;
    int        lo = 0;
    int        rr = 0;
    int        cnt = 0;
    bit        have_last = 1'b0;
    logic [15:0] la, ld;

    always @(negedge clk) begin : model
        logic [N-1:0] vb;
        logic [15:0]  fa, fd;
        bit           acc, wrb, rel, pre;
        vb = bus.m_valid;
        if (rst) begin
            chk("rst_ready", bus.m_ready, 0);
            chk("rst_wr", mem_wr, 0);
            mo = -1; lo = 0; rr = 0; cnt = 0; have_last = 1'b0;
        end else if (mo < 0) begin
            chk("idle_ready", bus.m_ready, 0);
            chk("idle_wr", mem_wr, 0);
            chk("idle_busy", busy, 0);
            chk("idle_gid", grant_id, lo);
            if (have_last) begin
                chk("idle_addr", mem_addr, la);
                chk("idle_wdata", mem_wdata, ld);
            end
            if (|vb) begin
                mo = pick(vb, rr); lo = mo; cnt = 0;
            end
        end else begin
            acc = ((vb >> mo) & 1) != 0;
            wrb = ((bus.m_wr >> mo) & 1) != 0;
            fa  = 16'(bus.m_addr >> (mo * AW));
            fd  = 16'(bus.m_wdata >> (mo * DW));
            chk("own_ready", bus.m_ready, acc ? (1 << mo) : 0);
            chk("own_wr", mem_wr, acc && wrb);
            chk("own_busy", busy, 1);
            chk("own_gid", grant_id, mo);
            chk("own_addr", mem_addr, fa);
            chk("own_wdata", mem_wdata, fd);
            la = fa; ld = fd; have_last = 1'b1;
            if (acc) cnt++;
            pre = PRIO && vb[0] && (mo != 0);
            rel = !acc || (cnt == MB) || pre;
            if (rel) begin
                rr  = (mo + 1) % N;
                cnt = 0;
                if (pre) mo = 0;
                else if (|vb) mo = pick(vb, rr);
                else mo = -1;
                if (mo >= 0) lo = mo;
            end
        end
        chk("rdata", bus.m_rdata, mem_rdata);
    end

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic set(input int i, input logic v, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
        bus.m_valid[i]         = v;
        bus.m_wr[i]            = w;
        bus.m_addr[i*AW +: AW] = a;
        bus.m_wdata[i*DW +: DW] = d;
    endtask

    int gs[8] = '{1, 1, 2, 2, 3, 3, 1, 1};
    int found;
    int n3;

    initial begin
        bus.m_valid = '0; bus.m_wr = '0; bus.m_addr = '0; bus.m_wdata = '0;
        bus2.m_valid = '0; bus2.m_wr = '0;
        bus2.m_addr = '0; bus2.m_wdata = '0;
        rst = 1'b1;
        nxt(); nxt();
        smp();
        chk("reset_busy", busy, 0);
        chk("reset_gid", grant_id, 0);
        chk("reset_ready", bus.m_ready, 0);
        nxt();
        rst = 1'b0;

        // 1: lone CPU requester, re-granted after 4 with no bubble
        set(0, 1, 0, 16'h0010, 16'h0000);
        for (int c = 0; c < 7; c++) begin
            smp();
            chk($sformatf("t1_ready_c%0d", c), bus.m_ready, (c == 0) ? 0 : 1);
            nxt();
        end
        set(0, 0, 0, 16'h0010, 16'h0000);
        smp(); nxt();

        // 3: master 2 write then read-back
        set(2, 1, 1, 16'h1234, 16'hBEEF);
        smp(); chk("t3_grant_wr", mem_wr, 0); nxt();
        smp();
        chk("t3_wr_ready", bus.m_ready, 4'b0100);
        chk("t3_wr", mem_wr, 1);
        chk("t3_addr", mem_addr, 16'h1234);
        chk("t3_wdata", mem_wdata, 16'hBEEF);
        nxt();
        set(2, 1, 0, 16'h1234, 16'h0000);
        smp();
        chk("t3_rd_ready", bus.m_ready, 4'b0100);
        chk("t3_rd_wr", mem_wr, 0);
        nxt();
        set(2, 0, 0, 16'h1234, 16'h0000);
        smp(); chk("t3_rdata", bus.m_rdata, 16'hBEEF); nxt();

        // 4: owner drops after one access, waiting master follows
        set(1, 1, 0, 16'h0100, 16'h0000);
        set(2, 1, 0, 16'h0200, 16'h0000);
        smp(); nxt();
        smp(); chk("t4_first", bus.m_ready, 4'b0010); nxt();
        set(1, 0, 0, 16'h0100, 16'h0000);
        smp(); chk("t4_bubble", bus.m_ready, 4'b0000); nxt();
        smp(); chk("t4_next", bus.m_ready, 4'b0100); nxt();
        set(2, 0, 0, 16'h0200, 16'h0000);
        smp(); nxt();

        // 5: reset in second cycle of a master 3 write burst
        set(3, 1, 1, 16'h0300, 16'h3333);
        smp(); nxt();
        smp(); chk("t5_first_wr", mem_wr, 1); nxt();
        rst = 1'b1;
        set(0, 1, 0, 16'h0040, 16'h0000);
        smp();
        chk("t5_rst_wr", mem_wr, 0);
        chk("t5_rst_ready", bus.m_ready, 0);
        nxt();
        rst = 1'b0;
        smp();
        chk("t5_busy", busy, 0);
        chk("t5_ready", bus.m_ready, 0);
        nxt();
        smp(); chk("t5_cpu_first", bus.m_ready, 4'b0001); nxt();
        set(0, 0, 0, 16'h0040, 16'h0000);
        smp(); nxt();

        // 6: CPU raises request while master 3 is mid-burst
        smp(); chk("t6_m3_start", bus.m_ready, 4'b1000); nxt();
        set(0, 1, 0, 16'h0050, 16'h0000);
        found = -1;
        n3 = 0;
        for (int k = 0; k < 20; k++) begin
            smp();
            if (bus.m_ready[0]) begin
                found = k;
                break;
            end
            if (bus.m_ready[3]) n3++;
            nxt();
        end
        chk("t6_cpu_wait", found, PRIO ? 1 : 3);
        chk("t6_m3_beats", n3, PRIO ? 1 : 3);
        nxt();
        set(0, 0, 0, 16'h0050, 16'h0000);
        set(3, 0, 0, 16'h0300, 16'h0000);
        smp(); nxt();
        smp(); nxt();

        // 2: three DMA masters, MAX_BURST=2
        bus2.m_valid = 4'b1110;
        smp(); chk("t2_c0_ready", bus2.m_ready, 0); nxt();
        for (int c = 0; c < 8; c++) begin
            smp();
            chk($sformatf("t2_gid_c%0d", c + 1), grant_id2, gs[c]);
            chk($sformatf("t2_ready_c%0d", c + 1), bus2.m_ready, 1 << gs[c]);
            nxt();
        end
        bus2.m_valid = '0;
        smp(); nxt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
